mult_pack: RTL

MULT_PACK -- requirements
Module: mult_pack

---
 rtl/mult_echo_pkg.sv | 14 +
 rtl/mult_pack_if.sv | 25 ++
 rtl/mult_pack_shot_gap_cnt.sv | 33 +++
 rtl/mult_pack.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mult_echo_pkg.sv
// Shared sizing and FSM state encoding for the multi-echo packer.
package mult_echo_pkg;
  localparam int unsigned ECHO_NUM = 5;
  localparam int unsigned PLUSE_W  = 8;
  localparam int unsigned DIST_W   = 16;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD,
    EMIT
  } state_e;
endpackage

// File: rtl/mult_pack_if.sv
// Echo input stream and packed frame output of mult_pack.
interface mult_pack_if;
  import mult_echo_pkg::*;

  logic                         shot_start;
  logic                         window_end;
  logic                         echo_valid;
  logic [PLUSE_W-1:0]           echo_pluse;
  logic [DIST_W-1:0]            echo_distance;
  logic [ECHO_NUM*PLUSE_W-1:0]  mult_pluse;
  logic [ECHO_NUM*DIST_W-1:0]   mult_distance;
  logic                         valid_m;
  logic [CNT_W-1:0]             echo_count;
  logic                         overflow;

  modport master (
    output shot_start, window_end, echo_valid, echo_pluse, echo_distance,
    input  mult_pluse, mult_distance, valid_m, echo_count, overflow
  );

  modport slave (
    input  shot_start, window_end, echo_valid, echo_pluse, echo_distance,
    output mult_pluse, mult_distance, valid_m, echo_count, overflow
  );
endinterface

// File: rtl/mult_pack_shot_gap_cnt.sv
// Saturating counter measuring spacing between published frames.
module shot_gap_cnt #(
  parameter logic [7:0] CLR_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  output logic [7:0] count,
  output logic       saturation
);
  logic [7:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = CLR_VAL;
    end else if (count_q != 8'hFF) begin
      count_d = count_q + 8'd1;
    end
  end

  // Preset to saturation so the first frame after reset is never held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'hFF;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign saturation = (count_q == 8'hFF);
endmodule

// File: rtl/mult_pack.sv
// Collects up to five echoes per laser shot and publishes them as one packed,
// rate-limited frame.
module mult_pack
  import mult_echo_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd200,
  parameter logic [7:0] MIN_GAP = 8'd100
) (
  input  logic        clk,
  input  logic        rst,
  mult_pack_if.slave  bus
);
  localparam logic [CNT_W-1:0] SLOTS = CNT_W'(ECHO_NUM);

  state_e                       state_d, state_q;
  logic [PLUSE_W-1:0]           pl_d [ECHO_NUM];
  logic [PLUSE_W-1:0]           pl_q [ECHO_NUM];
  logic [DIST_W-1:0]            ds_d [ECHO_NUM];
  logic [DIST_W-1:0]            ds_q [ECHO_NUM];
  logic [CNT_W-1:0]             cnt_d, cnt_q;
  logic                         drop_d, drop_q;
  logic [7:0]                   tmo_d, tmo_q;
  logic [ECHO_NUM*PLUSE_W-1:0]  mult_pluse_d, mult_pluse_q;
  logic [ECHO_NUM*DIST_W-1:0]   mult_distance_d, mult_distance_q;
  logic                         valid_m_d, valid_m_q;
  logic [CNT_W-1:0]             echo_count_d, echo_count_q;
  logic                         overflow_d, overflow_q;

  logic                         echo_hit;
  logic                         close_win;
  logic                         gap_clear;
  logic [7:0]                   gap_cnt;
  logic                         gap_sat;
  logic                         gap_ok;

  // Clearing to 2 makes gap_cnt equal the valid_m spacing that results if
  // EMIT is entered on the current edge, so frames land exactly MIN_GAP apart.
  shot_gap_cnt #(.CLR_VAL(8'd2)) u_gap (
    .clk        (clk),
    .rst        (rst),
    .clear      (gap_clear),
    .count      (gap_cnt),
    .saturation (gap_sat)
  );

  assign echo_hit  = bus.echo_valid && (bus.echo_distance != '0);
  assign close_win = bus.window_end || bus.shot_start || (tmo_q == TIMEOUT - 8'd1);
  assign gap_ok    = gap_sat || (gap_cnt >= MIN_GAP);

  always_comb begin
    state_d         = state_q;
    pl_d            = pl_q;
    ds_d            = ds_q;
    cnt_d           = cnt_q;
    drop_d          = drop_q;
    tmo_d           = tmo_q;
    mult_pluse_d    = mult_pluse_q;
    mult_distance_d = mult_distance_q;
    valid_m_d       = 1'b0;
    echo_count_d    = echo_count_q;
    overflow_d      = overflow_q;
    gap_clear       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.shot_start) begin
          pl_d   = '{default: '0};
          ds_d   = '{default: '0};
          cnt_d  = '0;
          drop_d = 1'b0;
          tmo_d  = '0;
          if (echo_hit) begin
            pl_d[0] = bus.echo_pluse;
            ds_d[0] = bus.echo_distance;
            cnt_d   = CNT_W'(1);
          end
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (echo_hit) begin
          if (cnt_q < SLOTS) begin
            pl_d[cnt_q] = bus.echo_pluse;
            ds_d[cnt_q] = bus.echo_distance;
            cnt_d       = cnt_q + CNT_W'(1);
          end else begin
            drop_d = 1'b1;
          end
        end
        if (tmo_q != 8'hFF) begin
          tmo_d = tmo_q + 8'd1;
        end
        if (close_win) begin
          state_d = gap_ok ? EMIT : HOLD;
        end
      end

      HOLD: begin
        if (gap_ok) begin
          state_d = EMIT;
        end
      end

      EMIT: begin
        for (int unsigned i = 0; i < ECHO_NUM; i++) begin
          mult_pluse_d[(ECHO_NUM-1-i)*PLUSE_W +: PLUSE_W]  = pl_q[i];
          mult_distance_d[(ECHO_NUM-1-i)*DIST_W +: DIST_W] = ds_q[i];
        end
        echo_count_d = cnt_q;
        overflow_d   = drop_q;
        valid_m_d    = 1'b1;
        gap_clear    = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      pl_q            <= '{default: '0};
      ds_q            <= '{default: '0};
      cnt_q           <= '0;
      drop_q          <= 1'b0;
      tmo_q           <= '0;
      mult_pluse_q    <= '0;
      mult_distance_q <= '0;
      valid_m_q       <= 1'b0;
      echo_count_q    <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pl_q            <= pl_d;
      ds_q            <= ds_d;
      cnt_q           <= cnt_d;
      drop_q          <= drop_d;
      tmo_q           <= tmo_d;
      mult_pluse_q    <= mult_pluse_d;
      mult_distance_q <= mult_distance_d;
      valid_m_q       <= valid_m_d;
      echo_count_q    <= echo_count_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bus.mult_pluse    = mult_pluse_q;
  assign bus.mult_distance = mult_distance_q;
  assign bus.valid_m       = valid_m_q;
  assign bus.echo_count    = echo_count_q;
  assign bus.overflow      = overflow_q;
endmodule
